// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light monitor: light codes, the decoded
// phase encoding, the fault cause encoding and the monitor state enum.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [3:0] CODE_RED = 4'b1000;
    localparam logic [3:0] CODE_YEL = 4'b0100;
    localparam logic [3:0] CODE_GRN = 4'b0010;
    localparam logic [3:0] CODE_RST = 4'b1010;  // controller in reset
    localparam logic [3:0] CODE_OFF = 4'b1111;  // controller disabled

    typedef enum logic [1:0] {
        PH_RED = 2'd0,
        PH_YEL = 2'd1,
        PH_GRN = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_SEQ     = 2'd2,
        FC_DWELL   = 2'd3
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    // Only permitted successor of each phase: red -> yellow -> green -> red.
    function automatic phase_t next_phase(phase_t p);
        case (p)
            PH_RED:  return PH_YEL;
            PH_YEL:  return PH_GRN;
            default: return PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor_if
// Bundles the monitor controls, the observed light code and the monitor
// status outputs.
//   en, clr, lights        : driven by the master (controller side)
//   phase, phase_valid,
//   fault, fault_code,
//   cycles, dwell          : driven by the slave (the monitor)
// -----------------------------------------------------------------------------
interface traffic_light_monitor_if;
    logic       en;
    logic       clr;
    logic [3:0] lights;
    logic [1:0] phase;
    logic       phase_valid;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] cycles;
    logic [7:0] dwell;

    modport master (
        output en, clr, lights,
        input  phase, phase_valid, fault, fault_code, cycles, dwell
    );

    modport slave (
        input  en, clr, lights,
        output phase, phase_valid, fault, fault_code, cycles, dwell
    );
endinterface

// File: rtl/tl_code_decoder.sv
// -----------------------------------------------------------------------------
// tl_code_decoder
// Combinational map of a 4-bit light code to a phase.
//   code_i    : light code
//   phase_o   : decoded phase (PH_RED when the code is not a phase code)
//   legal_o   : code is one of the three phase codes
//   neutral_o : code is controller-reset or controller-disabled
// -----------------------------------------------------------------------------
module tl_code_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] code_i,
    output phase_t     phase_o,
    output logic       legal_o,
    output logic       neutral_o
);

    always_comb begin
        phase_o   = PH_RED;
        legal_o   = 1'b0;
        neutral_o = 1'b0;
        case (code_i)
            CODE_RED: begin phase_o = PH_RED; legal_o = 1'b1; end
            CODE_YEL: begin phase_o = PH_YEL; legal_o = 1'b1; end
            CODE_GRN: begin phase_o = PH_GRN; legal_o = 1'b1; end
            CODE_RST,
            CODE_OFF: neutral_o = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Watches the light code of a traffic controller, checks phase order and
// phase dwell times, and latches the first fault seen.
//   clk : clock, rising edge
//   res : synchronous active-high reset
//   bus : slave side of traffic_light_monitor_if
//         in : en (freezes everything when low), clr (leave FAULT), lights
//         out: phase, phase_valid, fault, fault_code, cycles, dwell
// -----------------------------------------------------------------------------
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned T_RED = 10,
    parameter int unsigned T_YEL = 2,
    parameter int unsigned T_GRN = 8,
    parameter int unsigned TOL   = 1
) (
    input logic                      clk,
    input logic                      res,
    traffic_light_monitor_if.slave   bus
);

    function automatic int unsigned dwell_nom(phase_t p);
        case (p)
            PH_RED:  return T_RED;
            PH_YEL:  return T_YEL;
            default: return T_GRN;
        endcase
    endfunction

    function automatic int unsigned dwell_hi(phase_t p);
        return dwell_nom(p) + TOL;
    endfunction

    function automatic int unsigned dwell_lo(phase_t p);
        return (dwell_nom(p) > TOL) ? dwell_nom(p) - TOL : 32'd0;
    endfunction

    logic [3:0]  lights_q;   // registered sample that every check uses
    logic [3:0]  code_q;     // sample processed on the previous enabled edge
    mon_state_t  state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        fault_q, fault_d;
    fault_code_t fcode_q, fcode_d;
    logic [7:0]  cycles_q, cycles_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        first_q, first_d;  // current phase is the first since IDLE

    phase_t      dec_phase;
    logic        dec_legal;
    logic        dec_neutral;
    logic        changed;
    logic [7:0]  dwell_inc;
    fault_code_t new_fault;

    tl_code_decoder u_dec (
        .code_i    (lights_q),
        .phase_o   (dec_phase),
        .legal_o   (dec_legal),
        .neutral_o (dec_neutral)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        fault_d   = fault_q;
        fcode_d   = fcode_q;
        cycles_d  = cycles_q;
        first_d   = first_q;
        new_fault = FC_NONE;
        changed   = (lights_q != code_q);
        dwell_inc = changed ? 8'd1 : ((dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1);
        dwell_d   = dwell_inc;

        case (state_q)
            ST_IDLE: begin
                if (dec_neutral) begin
                    dwell_d = '0;
                end else if (!dec_legal) begin
                    new_fault = FC_ILLEGAL;
                end else begin
                    state_d = ST_TRACK;
                    phase_d = dec_phase;
                    dwell_d = 8'd1;
                    first_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (dec_neutral) begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                end else if (!dec_legal) begin
                    new_fault = FC_ILLEGAL;
                end else if (changed) begin
                    // Departing dwell is dwell_q; the lower bound is waived
                    // for the phase that was entered from IDLE.
                    if (dec_phase != next_phase(phase_q)) begin
                        new_fault = FC_SEQ;
                    end else if ((32'(dwell_q) > dwell_hi(phase_q)) ||
                                 (!first_q && (32'(dwell_q) < dwell_lo(phase_q)))) begin
                        new_fault = FC_DWELL;
                    end else begin
                        phase_d = dec_phase;
                        first_d = 1'b0;
                        if (phase_q == PH_GRN && cycles_q != 8'hFF)
                            cycles_d = cycles_q + 8'd1;
                    end
                end else if (32'(dwell_inc) > dwell_hi(phase_q)) begin
                    new_fault = FC_DWELL;
                end
            end
            ST_FAULT: begin
                if (bus.clr) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                    fcode_d = FC_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_fault != FC_NONE) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            fcode_d = new_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            lights_q <= CODE_RST;
            code_q   <= CODE_RST;
            state_q  <= ST_IDLE;
            phase_q  <= PH_RED;
            fault_q  <= 1'b0;
            fcode_q  <= FC_NONE;
            cycles_q <= '0;
            dwell_q  <= '0;
            first_q  <= 1'b0;
        end else if (bus.en) begin
            lights_q <= bus.lights;
            code_q   <= lights_q;
            state_q  <= state_d;
            phase_q  <= phase_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
            cycles_q <= cycles_d;
            dwell_q  <= dwell_d;
            first_q  <= first_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = (state_q == ST_TRACK);
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fcode_q;
    assign bus.cycles      = cycles_q;
    assign bus.dwell       = dwell_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
// Table-driven directed vectors, hand sequences for reset and a TOL=0 build,
// and randomized traffic checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    localparam int TR = 10;
    localparam int TY = 2;
    localparam int TG = 8;
    localparam int TL = 1;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    traffic_light_monitor_if bus ();
    traffic_light_monitor_if bus2 ();

    traffic_light_monitor #(.T_RED(TR), .T_YEL(TY), .T_GRN(TG), .TOL(TL)) dut (
        .clk (clk),
        .res (rst),
        .bus (bus)
    );

    traffic_light_monitor #(.T_RED(TR), .T_YEL(TY), .T_GRN(TG), .TOL(0)) dut0 (
        .clk (clk),
        .res (rst2),
        .bus (bus2)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int m_samp, m_prev, m_mode, m_run, m_ph, m_fault, m_fc, m_cyc, m_first;
    int TT[3] = '{TR, TY, TG};

    function automatic int ph_idx(int c);
        if (c == 8) return 0;
        if (c == 4) return 1;
        if (c == 2) return 2;
        return -1;
    endfunction

    task automatic model_step(bit r, bit e, bit cl, int lt);
        int c, k, nf, run_next;
        bit moved;
        if (r) begin
            m_samp = 10; m_prev = 10; m_mode = 0; m_run = 0; m_ph = 0;
            m_fault = 0; m_fc = 0; m_cyc = 0; m_first = 0;
        end else if (e) begin
            c = m_samp;
            k = ph_idx(c);
            nf = 0;
            moved = (c != m_prev);
            run_next = moved ? 1 : ((m_run < 255) ? m_run + 1 : 255);
            if (m_mode == 2) begin
                m_run = run_next;
                if (cl) begin m_mode = 0; m_fault = 0; m_fc = 0; end
            end else if (c == 10 || c == 15) begin
                m_mode = 0; m_run = 0;
            end else if (k < 0) begin
                nf = 1; m_run = run_next;
            end else if (m_mode == 0) begin
                m_mode = 1; m_ph = k; m_run = 1; m_first = 1;
            end else if (!moved) begin
                m_run = run_next;
                if (m_run > TT[m_ph] + TL) nf = 3;
            end else if (k != (m_ph + 1) % 3) begin
                nf = 2; m_run = 1;
            end else begin
                if (m_run > TT[m_ph] + TL || (!m_first && m_run < TT[m_ph] - TL)) nf = 3;
                else begin
                    if (m_ph == 2 && m_cyc < 255) m_cyc++;
                    m_ph = k; m_first = 0;
                end
                m_run = 1;
            end
            if (nf != 0) begin m_mode = 2; m_fault = 1; m_fc = nf; end
            m_prev = c;
            m_samp = lt;
        end
    endtask

    // ---------------- drivers and checks ----------------
    task automatic tick(bit r, bit e, bit cl, logic [3:0] l);
        rst = r; bus.en = e; bus.clr = cl; bus.lights = l;
        @(posedge clk);
        model_step(r, e, cl, int'(l));
        #1;
    endtask

    task automatic tick2(bit r, logic [3:0] l);
        rst2 = r; bus2.en = 1'b1; bus2.clr = 1'b0; bus2.lights = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [1:0] eph, logic epv, logic ef,
                         logic [1:0] efc, logic [7:0] ecy, logic [7:0] edw);
        total++;
        if ({bus.phase, bus.phase_valid, bus.fault, bus.fault_code, bus.cycles, bus.dwell}
            !== {eph, epv, ef, efc, ecy, edw}) begin
            bad++;
            $display("FAIL %s: got ph=%0d pv=%0d f=%0d fc=%0d cyc=%0d dw=%0d want ph=%0d pv=%0d f=%0d fc=%0d cyc=%0d dw=%0d",
                     nm, bus.phase, bus.phase_valid, bus.fault, bus.fault_code, bus.cycles, bus.dwell,
                     eph, epv, ef, efc, ecy, edw);
        end
    endtask

    task automatic check2(string nm, logic epv, logic ef, logic [1:0] efc);
        total++;
        if ({bus2.phase_valid, bus2.fault, bus2.fault_code} !== {epv, ef, efc}) begin
            bad++;
            $display("FAIL %s: got pv=%0d f=%0d fc=%0d want pv=%0d f=%0d fc=%0d",
                     nm, bus2.phase_valid, bus2.fault, bus2.fault_code, epv, ef, efc);
        end
    endtask

    typedef struct {
        bit         r, e, c;
        logic [3:0] l;
        int         reps;
        logic [1:0] ph;
        logic       pv, f;
        logic [1:0] fc;
        logic [7:0] cy, dw;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit c, logic [3:0] l, int reps,
                                logic [1:0] ph, logic pv, logic f, logic [1:0] fc,
                                logic [7:0] cy, logic [7:0] dw);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.l = l; v.reps = reps;
        v.ph = ph; v.pv = pv; v.f = f; v.fc = fc; v.cy = cy; v.dw = dw;
        return v;
    endfunction

    function automatic logic [3:0] succ(logic [3:0] c);
        if (c == 4'b1000) return 4'b0100;
        if (c == 4'b0100) return 4'b0010;
        return 4'b1000;
    endfunction

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] cur;
        int left, sel, k;

        //              r  e  c  lights   n   ph pv f fc cyc dw
        tbl[0]  = mk(1, 1, 0, 4'b1010,  2, 0, 0, 0, 0, 0,  0);   // reset
        tbl[1]  = mk(0, 1, 0, 4'b1000, 10, 0, 1, 0, 0, 0,  9);   // red x10
        tbl[2]  = mk(0, 1, 0, 4'b0100,  2, 1, 1, 0, 0, 0,  1);   // yellow x2
        tbl[3]  = mk(0, 1, 0, 4'b0010,  8, 2, 1, 0, 0, 0,  7);   // green x8
        tbl[4]  = mk(0, 1, 0, 4'b1000,  2, 0, 1, 0, 0, 1,  1);   // cycle done
        tbl[5]  = mk(0, 1, 0, 4'b1000,  3, 0, 1, 0, 0, 1,  4);
        tbl[6]  = mk(0, 0, 0, 4'b1000,  5, 0, 1, 0, 0, 1,  4);   // en low holds
        tbl[7]  = mk(0, 1, 0, 4'b1000,  7, 0, 1, 0, 0, 1, 11);   // at max dwell
        tbl[8]  = mk(0, 1, 0, 4'b1000,  1, 0, 0, 1, 3, 1, 12);   // timeout
        tbl[9]  = mk(0, 1, 1, 4'b1000,  1, 0, 0, 0, 0, 1, 13);   // clr
        tbl[10] = mk(0, 1, 0, 4'b1000,  1, 0, 1, 0, 0, 1,  1);   // re-track
        tbl[11] = mk(0, 1, 0, 4'b1101,  2, 0, 0, 1, 1, 1,  1);   // illegal
        tbl[12] = mk(0, 1, 1, 4'b1010,  1, 0, 0, 0, 0, 1,  2);   // clr
        tbl[13] = mk(0, 1, 0, 4'b1010,  1, 0, 0, 0, 0, 1,  0);
        tbl[14] = mk(0, 1, 0, 4'b0010,  4, 2, 1, 0, 0, 1,  3);
        tbl[15] = mk(0, 1, 0, 4'b1111,  2, 2, 0, 0, 0, 1,  0);   // disabled
        tbl[16] = mk(0, 1, 0, 4'b1000, 10, 0, 1, 0, 0, 1,  9);
        tbl[17] = mk(0, 1, 0, 4'b0010,  1, 0, 1, 0, 0, 1, 10);   // skip, 1 edge
        tbl[18] = mk(0, 1, 0, 4'b0010,  1, 0, 0, 1, 2, 1,  1);   // skip, 2 edges

        rst2 = 1'b1; bus2.en = 1'b1; bus2.clr = 1'b0; bus2.lights = 4'b1010;

        for (int i = 0; i < 19; i++) begin
            for (int j = 0; j < tbl[i].reps; j++)
                tick(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l);
            check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].pv, tbl[i].f,
                  tbl[i].fc, tbl[i].cy, tbl[i].dw);
        end

        // Reset out of FAULT, three full cycles, then reset mid-green.
        tick(1, 1, 0, 4'b1010);
        check("rst_in_fault", 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < TR; j++) tick(0, 1, 0, 4'b1000);
            for (int j = 0; j < TY; j++) tick(0, 1, 0, 4'b0100);
            for (int j = 0; j < ((n == 3) ? 4 : TG); j++) tick(0, 1, 0, 4'b0010);
        end
        check("green_cyc3", 2, 1, 0, 0, 3, 3);
        tick(1, 1, 1, 4'b0010);
        check("rst_mid_green", 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 4'b1000);
        check("rst_sample", 0, 0, 0, 0, 0, 0);

        // Short yellow on the TOL=0 build.
        tick2(1, 4'b1010);
        tick2(1, 4'b1010);
        for (int j = 0; j < TR; j++) tick2(0, 4'b1000);
        tick2(0, 4'b0100);
        tick2(0, 4'b0010);
        check2("short_yel_1", 1, 0, 0);
        tick2(0, 4'b0010);
        check2("short_yel_2", 0, 1, 3);

        // Randomized traffic against the model.
        tick(1, 1, 0, 4'b1010);
        cur = 4'b1000;
        left = TR;
        for (int i = 0; i < 2000; i++) begin
            if (left <= 0) begin
                sel = $urandom_range(0, 99);
                if (sel < 80)      cur = succ(cur);
                else if (sel < 88) cur = 4'($urandom_range(0, 15));
                else if (sel < 94) cur = ($urandom_range(0, 1) != 0) ? 4'b1010 : 4'b1111;
                else               cur = succ(succ(cur));
                k = ph_idx(int'(cur));
                if (k >= 0) left = TT[k] + $urandom_range(0, 4) - 2;
                else        left = $urandom_range(1, 4);
                if (left < 1) left = 1;
            end
            left--;
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, cur);
            check("rand", 2'(m_ph), m_mode == 1, m_fault[0], 2'(m_fc),
                  8'(m_cyc), 8'(m_run));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter T_RED, default 10, required dwell of code 4'b1000 in clk cycles.
REQ-002 Parameter T_YEL, default 2, required dwell of code 4'b0100.
REQ-003 Parameter T_GRN, default 8, required dwell of code 4'b0010.
REQ-004 Parameter TOL, default 1, allowed +/- dwell deviation in cycles.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 res  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  monitor enable; low freezes all state.
REQ-008 clr  input  1  clears sticky fault; returns the block to IDLE.
REQ-009 lights  input  4  light code driven by the traffic controller.
REQ-010 phase  output  2  decoded phase: 0 red (1000), 1 yellow (0100), 2 green (0010).
REQ-011 phase_valid  output  1  high while state is TRACK.
REQ-012 fault  output  1  sticky fault flag.
REQ-013 fault_code  output  2  first fault cause: 0 none, 1 illegal code, 2 sequence, 3 dwell.
REQ-014 cycles  output  8  completed red->yellow->green->red cycles; saturates at 255.
REQ-015 dwell  output  8  cycles the current registered code has been held; saturates at 255.

Function
REQ-016 lights shall be registered once when en=1; all checks use the registered sample; flags and state update on the next edge, giving 2-cycle latency from lights to flags.
REQ-017 States: IDLE, TRACK, FAULT.
REQ-018 Neutral codes: 1010 (controller reset) and 1111 (controller disabled); any state except FAULT shall go to IDLE with dwell=0 and no fault.
REQ-019 Legal phase codes: 1000, 0100, 0010; all other codes besides the neutral codes are illegal.
REQ-020 IDLE -> TRACK on the first legal phase code; phase loads, dwell=1; the minimum dwell check shall be waived for this first phase.
REQ-021 In TRACK the only legal transitions are 1000->0100->0010->1000; any other change between legal codes shall set fault_code=2.
REQ-022 On a legal transition, if the dwell of the departing phase is outside [T_x-TOL, T_x+TOL], fault_code shall be set to 3.
REQ-023 While a phase is held, dwell reaching T_x+TOL+1 shall set fault_code=3 immediately, without waiting for a transition.
REQ-024 An illegal code in IDLE or TRACK shall set fault_code=1.
REQ-025 Any fault shall set fault=1, enter FAULT, and drop phase_valid.
REQ-026 In FAULT, fault and fault_code shall hold, and later faults are ignored.
REQ-027 dwell shall reset to 1 on every change of the registered code and increment otherwise, saturating at 255.
REQ-028 cycles shall increment on each legal 0010->1000 transition without fault, saturating at 255; clr does not clear it.
REQ-029 With en=0: input is not sampled, and state, counters and outputs hold.
REQ-030 clr in FAULT -> IDLE with fault=0 and fault_code=0; clr in other states has no effect.
REQ-031 If clr and a new fault occur in the same cycle, the new fault wins.

Reset
REQ-032 res=1 shall force on the next edge: state IDLE, phase=0, phase_valid=0, fault=0, fault_code=0, cycles=0, dwell=0, lights register=1010.
REQ-033 res shall override en and clr, including mid-phase and in FAULT.

Structure
REQ-034 Shared package traffic_pkg shall hold the light-code constants, the phase encoding, the fault_code encoding and the monitor state enum.
REQ-035 A combinational sub-module tl_code_decoder shall map the 4-bit code to a phase, a legal flag and a neutral flag.

Verification
REQ-036 Bench shall cover the nominal sequence: reset, then 1000x10, 0100x2, 0010x8, 1000 -> phase_valid=1, fault=0, cycles=1.
REQ-037 Bench shall cover a short yellow: 1000x10, 0100x1 (TOL=0 build), then 0010 -> fault=1, fault_code=3.
REQ-038 Bench shall cover a sequence skip: 1000x10 then 0010 -> fault_code=2 two edges after 0010 is presented.
REQ-039 Bench shall cover an illegal code and clear: 1101 in TRACK -> fault_code=1; clr -> fault=0 and state IDLE; 1111 mid-phase -> IDLE with no fault.
REQ-040 Bench shall cover timeout and enable hold: red held 12 cycles (TOL=1) -> fault_code=3 at dwell 12; en=0 for 5 cycles mid-red -> dwell unchanged.
REQ-041 Bench shall cover reset mid-operation: res during green with cycles=3 -> all outputs return to their reset values on the next edge.
